// File: rtl/seg_scan_display.sv
// Multiplexed hex 7-segment scanner with leading-zero blanking and per-digit blink.
// Data loaded mid-frame is held pending and committed only at the frame wrap, so a frame never tears.
module seg_digit_lane (
    input  logic [3:0] nib,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] pat
);
    logic [7:0] glyph;

    always_comb begin
        case (nib)
            4'h0: glyph = 8'hFC;
            4'h1: glyph = 8'h60;
            4'h2: glyph = 8'hDA;
            4'h3: glyph = 8'hF2;
            4'h4: glyph = 8'h66;
            4'h5: glyph = 8'hB6;
            4'h6: glyph = 8'hBE;
            4'h7: glyph = 8'hE0;
            4'h8: glyph = 8'hFE;
            4'h9: glyph = 8'hE6;
            4'hA: glyph = 8'hEE;
            4'hB: glyph = 8'h3E;
            4'hC: glyph = 8'h1A;
            4'hD: glyph = 8'h7A;
            4'hE: glyph = 8'h9E;
            default: glyph = 8'h8E;
        endcase
        pat = blank ? 8'h00 : {glyph[7:1], dp};
    end
endmodule

module seg_scan_display #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  blank_lz,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     seg_en,
    output logic                  frame_tick,
    output logic                  load_ack
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [SW-1:0]             scan_cnt;
    logic [IW-1:0]             idx;
    logic [BW-1:0]             blink_cnt;
    logic                      blink_ph;
    logic [DIGITS-1:0][3:0]    data_nib, disp_data, pend_data;
    logic [DIGITS-1:0]         disp_dp, pend_dp;
    logic                      pending;
    logic [DIGITS-1:0]         lz_blank;
    logic [DIGITS-1:0][7:0]    lane_pat;
    logic                      scan_end, wrap;

    assign data_nib = data;
    assign scan_end = (scan_cnt == SCAN_LAST);
    assign wrap     = scan_end && (idx == IDX_LAST);

    // digit k is a leading zero if it and every digit above it are zero; digit 0 always shows
    always_comb begin
        logic z;
        z        = 1'b1;
        lz_blank = '0;
        for (int k = DIGITS - 1; k > 0; k--) begin
            z           = z & (disp_data[k] == 4'h0);
            lz_blank[k] = z;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_lane
        seg_digit_lane u_lane (
            .nib   (disp_data[k]),
            .dp    (disp_dp[k]),
            .blank ((blink_mask[k] & blink_ph) | (blank_lz & lz_blank[k])),
            .pat   (lane_pat[k])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt   <= '0;
            idx        <= '0;
            blink_cnt  <= '0;
            blink_ph   <= 1'b0;
            disp_data  <= '0;
            disp_dp    <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pending    <= 1'b0;
            seg_out    <= 8'hFF;
            seg_en     <= '1;
            frame_tick <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            scan_cnt   <= scan_end ? '0 : scan_cnt + 1'b1;
            if (scan_end)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            frame_tick <= wrap;
            load_ack   <= wrap && (pending || load);
            if (load) begin
                pend_data <= data_nib;
                pend_dp   <= dp_in;
            end
            if (wrap) begin
                // a load landing on the wrap cycle bypasses the pending buffer
                if (load) begin
                    disp_data <= data_nib;
                    disp_dp   <= dp_in;
                end else if (pending) begin
                    disp_data <= pend_data;
                    disp_dp   <= pend_dp;
                end
                pending <= 1'b0;
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
            seg_en  <= ~(DIGITS'(1) << idx);
            seg_out <= ~lane_pat[idx];
        end
    end
endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display at DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
module tb_seg_scan_display;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blink_mask = '0;
    logic        blank_lz = 1'b0;
    logic [7:0]  seg_out;
    logic [3:0]  seg_en;
    logic        frame_tick, load_ack;

    int n_chk = 0;
    int n_pass = 0;

    seg_scan_display #(.DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in),
        .blink_mask(blink_mask), .blank_lz(blank_lz), .seg_out(seg_out),
        .seg_en(seg_en), .frame_tick(frame_tick), .load_ack(load_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] dp);
        load = 1'b1; data = d; dp_in = dp;
        step(1);
        load = 1'b0;
    endtask

    // starts just after a wrap edge, ends just after the next one
    task automatic check_frame(input string tag, input logic [3:0][7:0] exp,
                               input logic ld, input logic [15:0] ld_d,
                               input logic [3:0] ld_dp, input logic exp_ack);
        logic [3:0] en_exp;
        for (int k = 0; k < 4; k++) begin
            step(1);
            en_exp = ~(4'b0001 << k);
            chk({tag, "_en"}, seg_en, en_exp);
            chk({tag, "_seg"}, seg_out, exp[k]);
            chk({tag, "_tick_mid"}, frame_tick, 1'b0);
            if (k == 0 && ld) begin
                pulse_load(ld_d, ld_dp);
                step(2);
            end else begin
                step(3);
            end
        end
        chk({tag, "_tick_end"}, frame_tick, 1'b1);
        chk({tag, "_ack_end"}, load_ack, exp_ack);
    endtask

    initial begin
        // 1: reset holds outputs dark regardless of load
        step(1);
        for (int i = 0; i < 3; i++) begin
            pulse_load(16'hFFFF, 4'hF);
            step(1);
            chk("rst_seg", seg_out, 8'hFF);
            chk("rst_en", seg_en, 4'hF);
            chk("rst_tick", frame_tick, 1'b0);
            chk("rst_ack", load_ack, 1'b0);
        end
        rst = 1'b1;
        step(1);
        chk("rel_en", seg_en, 4'hE);
        chk("rel_seg", seg_out, 8'h03);

        // 2: load before first wrap commits at the wrap
        pulse_load(16'h1234, 4'h0);
        step(14);
        chk("w0_tick", frame_tick, 1'b1);
        chk("w0_ack", load_ack, 1'b1);
        check_frame("f1234", {8'h9F, 8'h25, 8'h0D, 8'h99}, 1'b0, 16'h0, 4'h0, 1'b0);

        // 3: two mid-frame loads; frame in progress unchanged, last load wins
        pulse_load(16'h5555, 4'h0);
        chk("mid_d0", seg_out, 8'h99);
        step(4);
        chk("mid_d1", seg_out, 8'h0D);
        pulse_load(16'hABCD, 4'h0);
        chk("mid_d1b", seg_out, 8'h0D);
        step(3);
        chk("mid_d2", seg_out, 8'h25);
        step(4);
        chk("mid_d3", seg_out, 8'h9F);
        step(3);
        chk("mid_tick", frame_tick, 1'b1);
        chk("mid_ack", load_ack, 1'b1);
        check_frame("fABCD", {8'h11, 8'hC1, 8'hE5, 8'h85}, 1'b0, 16'h0, 4'h0, 1'b0);

        // 4: leading-zero blanking
        blank_lz = 1'b1;
        check_frame("lz_pre", {8'h11, 8'hC1, 8'hE5, 8'h85}, 1'b1, 16'h0050, 4'h0, 1'b1);
        check_frame("lz0050", {8'hFF, 8'hFF, 8'h49, 8'h03}, 1'b1, 16'h0000, 4'h0, 1'b1);
        check_frame("lz0000", {8'hFF, 8'hFF, 8'hFF, 8'h03}, 1'b0, 16'h0, 4'h0, 1'b0);
        blank_lz = 1'b0;

        // 6a: load on the wrap cycle commits directly
        step(15);
        load = 1'b1; data = 16'h1234; dp_in = 4'h0;
        step(1);
        load = 1'b0;
        chk("coin_tick", frame_tick, 1'b1);
        chk("coin_ack", load_ack, 1'b1);
        check_frame("coin", {8'h9F, 8'h25, 8'h0D, 8'h99}, 1'b0, 16'h0, 4'h0, 1'b0);

        // 6b: reset mid-scan is immediate and drops pending data
        step(5);
        pulse_load(16'h5678, 4'h0);
        #2 rst = 1'b0;
        #1;
        chk("amid_seg", seg_out, 8'hFF);
        chk("amid_en", seg_en, 4'hF);
        step(2);
        chk("amid_seg2", seg_out, 8'hFF);
        chk("amid_tick", frame_tick, 1'b0);
        rst = 1'b1;
        step(1);
        chk("rel2_en", seg_en, 4'hE);
        chk("rel2_seg", seg_out, 8'h03);
        step(15);
        chk("lost_tick", frame_tick, 1'b1);
        chk("lost_ack", load_ack, 1'b0);

        // 5: blink on digit 0, dp on digit 1; frames 2-3 dark
        blink_mask = 4'b0001;
        check_frame("bl_f1", {8'h03, 8'h03, 8'h03, 8'h03}, 1'b1, 16'h1234, 4'b0010, 1'b1);
        check_frame("bl_f2", {8'h9F, 8'h25, 8'h0C, 8'hFF}, 1'b0, 16'h0, 4'h0, 1'b0);
        check_frame("bl_f3", {8'h9F, 8'h25, 8'h0C, 8'hFF}, 1'b0, 16'h0, 4'h0, 1'b0);
        check_frame("bl_f4", {8'h9F, 8'h25, 8'h0C, 8'h99}, 1'b0, 16'h0, 4'h0, 1'b0);
        check_frame("bl_f5", {8'h9F, 8'h25, 8'h0C, 8'h99}, 1'b0, 16'h0, 4'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
